// File: rtl/rf_pkg.sv
// Shared defaults, types and helpers for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned N_DEF    = 5;
    localparam int unsigned NR_DEF   = 2;
    localparam int unsigned PW_DEF   = 2;

    typedef logic [N_DEF-1:0]    rf_addr_t;
    typedef logic [XLEN_DEF-1:0] rf_word_t;

    // Saturation value of a PW-bit outstanding-write counter.
    function automatic int unsigned cnt_max(input int unsigned pw);
        return (32'd1 << pw) - 32'd1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register outstanding-write counters: reserve increments, writeback
// decrements, flush clears; refuses reservations of a saturated register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we_i,
    input  logic [N-1:0]                     wa_i,
    input  logic                             rsv_en_i,
    input  logic [N-1:0]                     rsv_addr_i,
    input  logic                             flush_i,
    output logic [(2**N)-1:0][PW-1:0]        cnt_o,
    output logic                             rsv_stall_o
);

    localparam int unsigned DEPTH = 2 ** N;
    localparam logic [PW-1:0] CMAX = PW'(cnt_max(PW));

    logic [DEPTH-1:0][PW-1:0] cnt_q;
    logic [DEPTH-1:0][PW-1:0] cnt_d;
    logic                     stall;

    // A same-register writeback frees a slot, so a saturated reserve can still proceed.
    always_comb begin
        stall = 1'b0;
        if (rsv_en_i && (rsv_addr_i != '0) && !flush_i &&
            (cnt_q[rsv_addr_i] == CMAX) &&
            !(we_i && (wa_i == rsv_addr_i))) begin
            stall = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            logic inc;
            logic dec;
            inc = rsv_en_i && (rsv_addr_i == N'(r)) && (r != 0) && !stall && !flush_i;
            dec = we_i && (wa_i == N'(r)) && (cnt_q[r] != '0);
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + PW'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign rsv_stall_o = stall;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard.
// Optional write-through forwarding to read ports: define RF_BYPASS_EN.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned N    = N_DEF,
    parameter int unsigned NR   = NR_DEF,
    parameter int unsigned PW   = PW_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NR-1:0][N-1:0]      ra,
    output logic [NR-1:0][XLEN-1:0]   rd,
    output logic [NR-1:0]             rd_ready,
    input  logic                      we,
    input  logic [N-1:0]              wa,
    input  logic [XLEN-1:0]           wd,
    input  logic                      rsv_en,
    input  logic [N-1:0]              rsv_addr,
    output logic                      rsv_stall,
    input  logic                      flush
);

    localparam int unsigned DEPTH = 2 ** N;

    logic [XLEN-1:0]          rf_q [DEPTH];
    logic [DEPTH-1:0][PW-1:0] cnt;

    rf_scoreboard #(
        .N  (N),
        .PW (PW)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (we),
        .wa_i        (wa),
        .rsv_en_i    (rsv_en),
        .rsv_addr_i  (rsv_addr),
        .flush_i     (flush),
        .cnt_o       (cnt),
        .rsv_stall_o (rsv_stall)
    );

    // Data array; x0 is never written so it holds its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                rf_q[r] <= '0;
            end
        end else if (we && (wa != '0)) begin
            rf_q[wa] <= wd;
        end
    end

    always_comb begin
        rd       = '0;
        rd_ready = '1;
        for (int unsigned i = 0; i < NR; i++) begin
            if (ra[i] != '0) begin
                rd[i]       = rf_q[ra[i]];
                rd_ready[i] = (cnt[ra[i]] == '0);
`ifdef RF_BYPASS_EN
                // The write retiring now satisfies the reader unless more remain in flight.
                if (we && (ra[i] == wa)) begin
                    rd[i]       = wd;
                    rd_ready[i] = (cnt[wa] <= PW'(1)) && !(rsv_en && (rsv_addr == wa));
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 32x32, 2 read ports, PW=2).
module tb_regfile_sb;
    import rf_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic [1:0][4:0]       ra;
    logic [1:0][31:0]      rd;
    logic [1:0]            rd_ready;
    logic                  we;
    rf_addr_t              wa;
    rf_word_t              wd;
    logic                  rsv_en;
    rf_addr_t              rsv_addr;
    logic                  rsv_stall;
    logic                  flush;

    int vectors     = 0;
    int miscompares = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra),
        .rd        (rd),
        .rd_ready  (rd_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_stall (rsv_stall),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Clock edge, then return all control inputs to idle and let reads settle.
    task automatic cyc();
        @(posedge clk);
        #1;
        we       = 1'b0;
        rsv_en   = 1'b0;
        flush    = 1'b0;
        wa       = '0;
        wd       = '0;
        rsv_addr = '0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        ra[0] = 5'd0; ra[1] = 5'd0;
        #2;
        chk("reset_rd", 64'(rd), 64'h0);
        chk("reset_ready", 64'(rd_ready), 64'h3);
        chk("reset_stall", 64'(rsv_stall), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // All registers read zero and ready on both ports.
        for (int r = 0; r < 32; r++) begin
            ra[0] = 5'(r);
            ra[1] = 5'(31 - r);
            #1;
            chk($sformatf("init_rd_x%0d", r), 64'(rd), 64'h0);
            chk($sformatf("init_ready_x%0d", r), 64'(rd_ready), 64'h3);
        end

        // Plain write, visible next cycle.
        ra[0] = 5'd5; ra[1] = 5'd0;
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        #1;
`ifndef RF_BYPASS_EN
        chk("x5_before_edge", 64'(rd[0]), 64'h0);
`else
        chk("x5_bypass", 64'(rd[0]), 64'hDEADBEEF);
`endif
        cyc();
        chk("x5_rd", 64'(rd[0]), 64'hDEADBEEF);
        chk("x5_ready", 64'(rd_ready[0]), 64'h1);

        // x0 ignores writes and reservations.
        ra[0] = 5'd0;
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1;
        chk("x0_stall", 64'(rsv_stall), 64'h0);
        chk("x0_rd_same", 64'(rd[0]), 64'h0);
        cyc();
        chk("x0_rd", 64'(rd[0]), 64'h0);
        chk("x0_ready", 64'(rd_ready[0]), 64'h1);

        // Saturate x7 (max 3 pending), then drain it.
        ra[0] = 5'd7;
        for (int k = 0; k < 3; k++) begin
            rsv_en = 1'b1; rsv_addr = 5'd7;
            #1;
            chk($sformatf("x7_rsv%0d_stall", k), 64'(rsv_stall), 64'h0);
            cyc();
            chk($sformatf("x7_rsv%0d_ready", k), 64'(rd_ready[0]), 64'h0);
        end
        rsv_en = 1'b1; rsv_addr = 5'd7;
        #1;
        chk("x7_sat_stall", 64'(rsv_stall), 64'h1);
        cyc();
        // At max, a same-register writeback lets the reserve through and the count holds.
        rsv_en = 1'b1; rsv_addr = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h70;
        #1;
        chk("x7_sat_wb_stall", 64'(rsv_stall), 64'h0);
        cyc();
        chk("x7_hold3_ready", 64'(rd_ready[0]), 64'h0);
        we = 1'b1; wa = 5'd7; wd = 32'h71;
        cyc();
        chk("x7_wb1_ready", 64'(rd_ready[0]), 64'h0);
        we = 1'b1; wa = 5'd7; wd = 32'h72;
        cyc();
        chk("x7_wb2_ready", 64'(rd_ready[0]), 64'h0);
        rsv_en = 1'b1; rsv_addr = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h73;
        cyc();
        chk("x7_hold1_ready", 64'(rd_ready[0]), 64'h0);
        we = 1'b1; wa = 5'd7; wd = 32'h74;
        cyc();
        chk("x7_wb3_ready", 64'(rd_ready[0]), 64'h1);
        chk("x7_wb3_rd", 64'(rd[0]), 64'h74);
        // Count is now 0: one more writeback must not underflow.
        we = 1'b1; wa = 5'd7; wd = 32'h75;
        cyc();
        chk("x7_nounder_ready", 64'(rd_ready[0]), 64'h1);
        chk("x7_nounder_rd", 64'(rd[0]), 64'h75);
        rsv_en = 1'b1; rsv_addr = 5'd7;
        cyc();
        chk("x7_rsv_after_under", 64'(rd_ready[0]), 64'h0);
        we = 1'b1; wa = 5'd7; wd = 32'h76;
        cyc();
        chk("x7_final_ready", 64'(rd_ready[0]), 64'h1);

        // Flush clears pending counts, drops a same-cycle reserve, keeps the write.
        rsv_en = 1'b1; rsv_addr = 5'd3;
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd4;
        cyc();
        ra[0] = 5'd3; ra[1] = 5'd4;
        #1;
        chk("pre_flush_ready", 64'(rd_ready), 64'h0);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd9;
        we = 1'b1; wa = 5'd3; wd = 32'h55;
        #1;
        chk("flush_stall", 64'(rsv_stall), 64'h0);
        cyc();
        chk("flush_ready", 64'(rd_ready), 64'h3);
        chk("flush_x3", 64'(rd[0]), 64'h55);
        ra[0] = 5'd9;
        #1;
        chk("flush_x9_ready", 64'(rd_ready[0]), 64'h1);

        // Write landing on a register with one pending write.
        ra[1] = 5'd0;
        we = 1'b1; wa = 5'd2; wd = 32'h1111;
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd2;
        cyc();
        ra[0] = 5'd2;
        #1;
        chk("x2_pending", 64'(rd_ready[0]), 64'h0);
        we = 1'b1; wa = 5'd2; wd = 32'h1234;
        #1;
`ifdef RF_BYPASS_EN
        chk("x2_fwd_rd", 64'(rd[0]), 64'h1234);
        chk("x2_fwd_ready", 64'(rd_ready[0]), 64'h1);
`else
        chk("x2_nofwd_rd", 64'(rd[0]), 64'h1111);
        chk("x2_nofwd_ready", 64'(rd_ready[0]), 64'h0);
`endif
        cyc();
        chk("x2_after_rd", 64'(rd[0]), 64'h1234);
        chk("x2_after_ready", 64'(rd_ready[0]), 64'h1);

        // Asynchronous reset mid-cycle with x6 pending twice.
        we = 1'b1; wa = 5'd6; wd = 32'hAA;
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd6;
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd6;
        cyc();
        ra[0] = 5'd6;
        #1;
        chk("x6_pre_rd", 64'(rd[0]), 64'hAA);
        chk("x6_pre_ready", 64'(rd_ready[0]), 64'h0);
        we = 1'b1; wa = 5'd6; wd = 32'hBB;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        #1;
        rst_n = 1'b0;
        #1;
        we = 1'b0; rsv_en = 1'b0;
        #1;
        chk("arst_rd", 64'(rd[0]), 64'h0);
        chk("arst_ready", 64'(rd_ready[0]), 64'h1);
        chk("arst_stall", 64'(rsv_stall), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_x6_rd", 64'(rd[0]), 64'h0);
        chk("post_rst_x6_ready", 64'(rd_ready[0]), 64'h1);
        ra[0] = 5'd5;
        #1;
        chk("post_rst_x5_rd", 64'(rd[0]), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
